// File: rtl/dst_axis_out.sv
// Output stage: captures batch-controller read beats into a FIFO and sources them as an AXI4-Stream master.
// Latency: a beat pushed into an empty FIFO is presented on m_tdata the next cycle.
// Backpressure: dst_ready is a credit decoded from the registered count, leaving room for the beat already in flight.

module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_vld,
    input  logic [W-1:0]               wr_dat,
    input  logic                       rd_rdy,
    output logic                       rd_vld,
    output logic [W-1:0]               rd_dat,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop;
    logic          full;
    logic          store;

    assign rd_vld = (count != '0);
    assign rd_dat = mem[rd_ptr];
    assign pop    = rd_vld & rd_rdy;
    assign full   = (count == CW'(DEPTH));
    // A write at full is only taken when the head leaves in the same cycle.
    assign store  = wr_vld & (~full | pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (store)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (store & ~pop)
                count <= count + 1'b1;
            else if (~store & pop)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (~reset & store)
            mem[wr_ptr] <= wr_dat;
    end
endmodule

module dst_axis_out #(
    parameter int DW    = 64,
    parameter int DEPTH = 4,
    parameter int BEATS = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic          last,
    input  logic          dst_valid,
    input  logic [DW-1:0] dst_data,
    output logic          dst_ready,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic [DW-1:0] m_tdata,
    output logic          m_tlast,
    output logic          blk_done,
    output logic          overflow
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef struct packed {
        logic          blk_end;
        logic          tlast;
        logic [DW-1:0] data;
    } entry_t;

    logic          clr;
    logic          den_d;
    logic [BW-1:0] bc;
    logic          bc_end;
    logic          push;
    logic          pop;
    logic [CW-1:0] count;
    entry_t        wr_entry;
    entry_t        head;

    assign clr       = reset | ~run;
    assign bc_end    = (bc == BW'(BEATS - 1));
    // den_d marks a beat loaded on an edge that saw dst_ready; held repeats are dropped.
    assign push      = dst_valid & den_d;
    assign pop       = m_tvalid & m_tready;
    assign dst_ready = (count < CW'(DEPTH - 1));

    assign wr_entry.blk_end = bc_end;
    assign wr_entry.tlast   = bc_end & last;
    assign wr_entry.data    = dst_data;

    fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (clr),
        .wr_vld (push),
        .wr_dat (wr_entry),
        .rd_rdy (m_tready),
        .rd_vld (m_tvalid),
        .rd_dat (head),
        .count  (count)
    );

    assign m_tdata = head.data;
    assign m_tlast = m_tvalid & head.tlast;

    always_ff @(posedge clk) begin
        if (clr) begin
            den_d    <= 1'b0;
            bc       <= '0;
            blk_done <= 1'b0;
            overflow <= 1'b0;
        end else begin
            den_d    <= dst_ready;
            blk_done <= pop & head.blk_end;
            // The beat counter tracks upstream addresses, so it advances even on a dropped beat.
            if (push)
                bc <= bc_end ? '0 : bc + 1'b1;
            if (push & ~pop & (count == CW'(DEPTH)))
                overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dst_axis_out.sv
// Bench for dst_axis_out: queue-based reference model compared every cycle, plus literal per-scenario expectations.
module tb_dst_axis_out;
    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        last;
    logic        dst_valid;
    logic [63:0] dst_data;
    logic        dst_ready;
    logic        m_tvalid;
    logic        m_tready;
    logic [63:0] m_tdata;
    logic        m_tlast;
    logic        blk_done;
    logic        overflow;

    dst_axis_out #(.DW(64), .DEPTH(4), .BEATS(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .last      (last),
        .dst_valid (dst_valid),
        .dst_data  (dst_data),
        .dst_ready (dst_ready),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tdata   (m_tdata),
        .m_tlast   (m_tlast),
        .blk_done  (blk_done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        be;
        logic        tl;
        logic [63:0] d;
    } ent_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    ent_t q[$];
    ent_t out_log[$];
    int   m_bc;
    bit   m_den;
    bit   m_ovf;
    bit   m_blk;
    bit   live     = 1'b0;
    bit   forcing  = 1'b0;
    int   blk_cnt;
    bit   rdy_dropped;
    int   sz;
    bit   p_pop;
    bit   p_push;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a queue of pending beats, updated once per rising edge.
    always @(posedge clk) begin
        if (reset || !run) begin
            q.delete();
            m_bc  = 0;
            m_den = 1'b0;
            m_ovf = 1'b0;
            m_blk = 1'b0;
            live  = 1'b1;
        end else if (live) begin
            sz     = q.size();
            p_pop  = (sz != 0) && m_tready;
            p_push = dst_valid && (m_den || forcing);
            m_blk  = p_pop && q[0].be;
            if (p_pop)
                void'(q.pop_front());
            if (p_push) begin
                if (sz == 4 && !p_pop)
                    m_ovf = 1'b1;
                else
                    q.push_back('{be: (m_bc == 7), tl: (m_bc == 7) && last, d: dst_data});
                m_bc = (m_bc + 1) % 8;
            end
            m_den = (sz < 3);
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("m_tvalid", {63'd0, m_tvalid}, {63'd0, q.size() != 0});
            if (q.size() != 0) begin
                chk("m_tdata", m_tdata, q[0].d);
                chk("m_tlast", {63'd0, m_tlast}, {63'd0, q[0].tl});
            end else begin
                chk("m_tlast_idle", {63'd0, m_tlast}, 64'd0);
            end
            chk("dst_ready", {63'd0, dst_ready}, {63'd0, q.size() < 3});
            chk("overflow", {63'd0, overflow}, {63'd0, m_ovf});
            chk("blk_done", {63'd0, blk_done}, {63'd0, m_blk});
            if (m_tvalid && m_tready && run && !reset)
                out_log.push_back('{be: 1'b0, tl: m_tlast, d: m_tdata});
            if (blk_done)
                blk_cnt++;
            if (!dst_ready)
                rdy_dropped = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        out_log.delete();
        blk_cnt     = 0;
        rdy_dropped = 1'b0;
    endtask

    // Emulates the upstream beat flop: it only loads a new beat on edges that see dst_ready.
    task automatic send_block(input logic [63:0] base, input int n, input logic lastv, input int stall);
        int idx  = 0;
        int cyc  = 0;
        bit done = 1'b0;
        bit en;
        last = lastv;
        while (!done && cyc < 300) begin
            m_tready = (cyc >= stall);
            @(negedge clk);
            en = dst_ready;
            tick();
            if (en) begin
                if (idx < n) begin
                    dst_valid = 1'b1;
                    dst_data  = base + 64'(idx);
                    idx++;
                end else begin
                    dst_valid = 1'b0;
                end
            end
            cyc++;
            done = (idx == n) && !dst_valid && !m_tvalid;
        end
        chk("block_timeout", {63'd0, done}, 64'd1);
        m_tready = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        run       = 1'b1;
        last      = 1'b0;
        dst_valid = 1'b0;
        dst_data  = '0;
        m_tready  = 1'b1;
        blk_cnt   = 0;
        rdy_dropped = 1'b0;
        repeat (3) tick();
        chk("rst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
        chk("rst_dst_ready", {63'd0, dst_ready}, 64'd1);
        chk("rst_m_tlast", {63'd0, m_tlast}, 64'd0);
        chk("rst_blk_done", {63'd0, blk_done}, 64'd0);
        chk("rst_overflow", {63'd0, overflow}, 64'd0);
        reset = 1'b0;
        repeat (2) tick();

        // Normal block
        clear_log();
        send_block(64'd0, 8, 1'b0, 0);
        chk("norm_count", 64'(out_log.size()), 64'd8);
        for (int i = 0; i < out_log.size(); i++) begin
            chk("norm_data", out_log[i].d, 64'(i));
            chk("norm_tlast", {63'd0, out_log[i].tl}, 64'd0);
        end
        chk("norm_blk_cnt", 64'(blk_cnt), 64'd1);
        chk("norm_rdy_held", {63'd0, rdy_dropped}, 64'd0);

        // Backpressure
        clear_log();
        send_block(64'd0, 8, 1'b0, 12);
        chk("bp_count", 64'(out_log.size()), 64'd8);
        for (int i = 0; i < out_log.size(); i++)
            chk("bp_data", out_log[i].d, 64'(i));
        chk("bp_rdy_dropped", {63'd0, rdy_dropped}, 64'd1);
        chk("bp_overflow", {63'd0, overflow}, 64'd0);

        // Final batch: two blocks with last held high
        clear_log();
        send_block(64'h10, 8, 1'b1, 0);
        send_block(64'h20, 8, 1'b1, 0);
        chk("fin_count", 64'(out_log.size()), 64'd16);
        for (int i = 0; i < out_log.size(); i++) begin
            chk("fin_data", out_log[i].d, (i < 8) ? 64'h10 + 64'(i) : 64'h20 + 64'(i - 8));
            chk("fin_tlast", {63'd0, out_log[i].tl}, {63'd0, (i == 7) || (i == 15)});
        end
        chk("fin_blk_cnt", 64'(blk_cnt), 64'd2);
        last = 1'b0;

        // Stale-hold filter: a beat sits on dst_valid while dst_ready is low
        clear_log();
        send_block(64'h60, 4, 1'b0, 8);
        chk("stale_count", 64'(out_log.size()), 64'd4);
        for (int i = 0; i < out_log.size(); i++)
            chk("stale_data", out_log[i].d, 64'h60 + 64'(i));
        chk("stale_rdy_dropped", {63'd0, rdy_dropped}, 64'd1);

        // Flush with three entries queued
        clear_log();
        m_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dst_valid = 1'b1;
            dst_data  = 64'h30 + 64'(i);
            tick();
        end
        dst_valid = 1'b0;
        tick();
        chk("pre_flush_tvalid", {63'd0, m_tvalid}, 64'd1);
        chk("pre_flush_ready", {63'd0, dst_ready}, 64'd0);
        run = 1'b0;
        tick();
        run = 1'b1;
        chk("flush_tvalid", {63'd0, m_tvalid}, 64'd0);
        chk("flush_ready", {63'd0, dst_ready}, 64'd1);
        chk("flush_tlast", {63'd0, m_tlast}, 64'd0);
        repeat (2) tick();
        chk("flush_no_beats", 64'(out_log.size()), 64'd0);
        send_block(64'h40, 8, 1'b1, 0);
        chk("post_flush_count", 64'(out_log.size()), 64'd8);
        for (int i = 0; i < out_log.size(); i++) begin
            chk("post_flush_data", out_log[i].d, 64'h40 + 64'(i));
            chk("post_flush_tlast", {63'd0, out_log[i].tl}, {63'd0, i == 7});
        end
        last = 1'b0;

        // Forced overflow: den_d pinned high so every held beat counts as a push
        clear_log();
        m_tready = 1'b0;
        force dut.den_d = 1'b1;
        forcing = 1'b1;
        for (int i = 0; i < 6; i++) begin
            dst_valid = 1'b1;
            dst_data  = 64'h50 + 64'(i);
            tick();
        end
        dst_valid = 1'b0;
        release dut.den_d;
        forcing = 1'b0;
        chk("ovf_set", {63'd0, overflow}, 64'd1);
        chk("ovf_full_ready", {63'd0, dst_ready}, 64'd0);
        m_tready = 1'b1;
        repeat (8) tick();
        chk("ovf_count", 64'(out_log.size()), 64'd4);
        for (int i = 0; i < out_log.size(); i++)
            chk("ovf_data", out_log[i].d, 64'h50 + 64'(i));
        chk("ovf_sticky", {63'd0, overflow}, 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("ovf_cleared", {63'd0, overflow}, 64'd0);
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
